// File: rtl/state_led_if.sv
// Display-side bundle between the charger controller and the LED driver.
// STATE_LED_DIM_EN adds the 4-bit brightness input.
interface state_led_if #(
    parameter int unsigned STATE_W  = 3,
    parameter int unsigned NUM_LEDS = 5
);
    logic                en;
    logic [STATE_W-1:0]  state;
    logic [NUM_LEDS-1:0] blink_mask;
    logic [NUM_LEDS-1:0] light;
    logic                state_chg;
`ifdef STATE_LED_DIM_EN
    logic [3:0]          brightness;

    modport master (output en, state, blink_mask, brightness, input light, state_chg);
    modport slave  (input en, state, blink_mask, brightness, output light, state_chg);
`else
    modport master (output en, state, blink_mask, input light, state_chg);
    modport slave  (input en, state, blink_mask, output light, state_chg);
`endif
endinterface

// File: rtl/state_led_driver.sv
// Decodes the controller state onto a one-hot LED bar with per-LED blinking, a change flash
// and enable gating. Define STATE_LED_DIM_EN for PWM brightness control.
module state_led_driver #(
    parameter int unsigned STATE_W      = 3,
    parameter int unsigned NUM_LEDS     = 5,
    parameter int unsigned BLINK_HALF   = 25000000,
    parameter int unsigned FLASH_CYCLES = 12500000
) (
    input logic        clk,
    input logic        rst_n,
    state_led_if.slave bus_io
);
    localparam int unsigned CntW   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int unsigned FlashW = (FLASH_CYCLES > 0) ? $clog2(FLASH_CYCLES + 1) : 1;
    localparam logic [CntW-1:0]   CntMax    = CntW'(BLINK_HALF - 1);
    localparam logic [FlashW-1:0] FlashLoad = FlashW'(FLASH_CYCLES);
    localparam logic [FlashW-1:0] FlashOne  = FlashW'(1);

    logic [STATE_W-1:0]  prev_q, prev_d;
    logic [CntW-1:0]     cnt_q, cnt_d, cnt_eff;
    logic                phase_q, phase_d, phase_eff;
    logic [FlashW-1:0]   flash_q, flash_d;
    logic [NUM_LEDS-1:0] light_q, light_d, onehot;
    logic                chg_q, chg_d, chg, restart;
`ifdef STATE_LED_DIM_EN
    logic [3:0]          pwm_q, pwm_d;
`endif

    always_comb begin
        onehot = '0;
        for (int k = 0; k < NUM_LEDS; k++) begin
            if (bus_io.state == STATE_W'(k)) onehot[NUM_LEDS-1-k] = 1'b1;
        end
    end

    always_comb begin
        chg       = bus_io.en && (bus_io.state != prev_q);
        prev_d    = bus_io.state;
        chg_d     = chg;
        // The blink divider restarts on a change and on the last cycle of a flash, so the
        // first decoded cycle always shows the LED lit.
        restart   = chg || (flash_q == FlashOne);
        cnt_eff   = restart ? '0 : cnt_q;
        phase_eff = restart ? 1'b1 : phase_q;
        cnt_d     = '0;
        phase_d   = 1'b1;
        flash_d   = '0;
        light_d   = '0;
        if (bus_io.en) begin
            if (cnt_eff == CntMax) begin
                cnt_d   = '0;
                phase_d = ~phase_eff;
            end else begin
                cnt_d   = cnt_eff + 1'b1;
                phase_d = phase_eff;
            end
            if (chg) flash_d = FlashLoad;
            else if (flash_q != '0) flash_d = flash_q - 1'b1;
            else flash_d = flash_q;
            if ((chg && FLASH_CYCLES != 0) || (flash_q > FlashOne)) begin
                light_d = '1;
            end else begin
                light_d = onehot & ~(bus_io.blink_mask & {NUM_LEDS{~phase_eff}});
            end
        end
`ifdef STATE_LED_DIM_EN
        pwm_d   = (pwm_q == 4'd14) ? 4'd0 : pwm_q + 4'd1;
        light_d = light_d & {NUM_LEDS{pwm_q < bus_io.brightness}};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b1;
            flash_q <= '0;
            light_q <= '0;
            chg_q   <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            flash_q <= flash_d;
            light_q <= light_d;
            chg_q   <= chg_d;
        end
    end

`ifdef STATE_LED_DIM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_q <= 4'd0;
        else        pwm_q <= pwm_d;
    end
`endif

    assign bus_io.light     = light_q;
    assign bus_io.state_chg = chg_q;
endmodule
